mdu: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width. Sits beside the single-cycle `alu` in the execute stage: the pipeline issues MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO here, stalls on `busy`, and reads HI/LO through `result`. One operand bit is processed per cycle; an exception flush cancels an operation in flight.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 33 +++
 rtl/mdu.sv | 153 +++++++++++++++
 tb/tb_mdu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes, FSM state type and op-class helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MFHI  = 4'd4;
    localparam logic [3:0] MDU_MFLO  = 4'd5;
    localparam logic [3:0] MDU_MTHI  = 4'd6;
    localparam logic [3:0] MDU_MTLO  = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    // MULT/MULTU/DIV/DIVU occupy codes 0..3
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op == MDU_MULT || op == MDU_DIV;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of shift-add multiply or restoring divide.
//   is_div : 1 selects restoring-divide step, 0 selects shift-add step
//   acc_i  : accumulator, [2W:W] partial sum / remainder, [W-1:0] multiplier / quotient bits
//   b      : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o  : accumulator after one step
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH:0] mul_acc;
    logic [2*WIDTH:0] shifted;

    always_comb begin
        // add multiplicand under the current multiplier bit, then shift the whole accumulator right
        sum     = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
        mul_acc = {1'b0, sum, acc_i[WIDTH-1:1]};
        // shift next dividend bit into the remainder and trial-subtract; borrow means restore
        shifted = {acc_i[2*WIDTH-1:0], 1'b0};
        diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, b};
        acc_o   = !is_div ? mul_acc :
                  diff[WIDTH+1] ? shifted : {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with HI/LO registers, one operand bit per cycle.
//   clk, rst (async, active-low)
//   start, op, in1, in2 : issue strobe, operation, rs/rt operands
//   cancel              : abort an operation in flight
//   busy, done, div_zero: in flight, HI/LO just written by MULT/DIV, last divide had zero divisor
//   hi, lo, result      : architectural registers and MFHI/MFLO read port
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_p_q, neg_p_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic             sa, sb, op_div;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] prod;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .b      (b_q),
        .acc_o  (acc_step)
    );

    always_comb begin
        sa     = is_signed_op(op) & in1[WIDTH-1];
        sb     = is_signed_op(op) & in2[WIDTH-1];
        mag_a  = sa ? -in1 : in1;
        mag_b  = sb ? -in2 : in2;
        op_div = op == MDU_DIV || op == MDU_DIVU;
        // sign fix-up: product and quotient follow sign mismatch, remainder follows dividend
        prod   = neg_p_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo    = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_p_d    = neg_p_q;
        neg_r_d    = neg_r_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    hi_d = op == MDU_MTHI ? in1 : hi_q;
                    lo_d = op == MDU_MTLO ? in1 : lo_q;
                    if (is_muldiv(op)) begin
                        state_d    = S_CALC;
                        cnt_d      = CW'(WIDTH);
                        // low half holds the bits consumed per step: multiplier or dividend
                        acc_d      = {{(WIDTH+1){1'b0}}, op_div ? mag_a : mag_b};
                        b_d        = op_div ? mag_b : mag_a;
                        is_div_d   = op_div;
                        neg_p_d    = sa ^ sb;
                        neg_r_d    = sa;
                        dz_d       = op_div && in2 == '0;
                        div_zero_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = acc_step;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == CW'(1) ? S_FIX : S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    hi_d       = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d       = is_div_q ? quo : prod[WIDTH-1:0];
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_p_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_p_q    <= neg_p_d;
            neg_r_q    <= neg_r_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = state_q != S_IDLE;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign result   = op == MDU_MFHI ? hi_q : op == MDU_MFLO ? lo_q : '0;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: vector table, hand sequences and random ops against an arithmetic model, for WIDTH 32 and 8.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = MDU_MFHI;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        cancel = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo, result;

    logic        rst8 = 1'b0;
    logic        start8 = 1'b0;
    logic [3:0]  op8 = MDU_MFHI;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cancel8 = 1'b0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8, res8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2), .cancel(cancel),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo), .result(result)
    );

    mdu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .in1(a8), .in2(b8), .cancel(cancel8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8), .result(res8)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain SV arithmetic; signed / and % truncate toward zero like the hardware.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        edz = 1'b0;
        eh = '0;
        el = '0;
        if (o == MDU_MULT) begin
            sp = sa * sb;
            {eh, el} = sp;
        end else if (o == MDU_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            {eh, el} = up;
        end else if (b == 32'd0) begin
            edz = 1'b1;
            eh = a;
            el = (o == MDU_DIV && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (o == MDU_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            el = sq[31:0];
            eh = sr[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    // Issue at a negedge, then watch 40 cycles; cycle 1 is the one after the issue edge.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int intr, input int cxl,
                          output int dcyc, output int ndone, output int berr, output logic dz1);
        @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1; cancel = 1'b0;
        dcyc = 0; ndone = 0; berr = 0; dz1 = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == intr);
            cancel = (c == cxl);
            if (c == intr) begin
                in1 = 32'd7;
                in2 = 32'd7;
            end
            if (c == 1) dz1 = div_zero;
            if (busy !== (c <= (cxl > 0 ? cxl : 33))) berr++;
            if (done === 1'b1) begin
                ndone++;
                if (dcyc == 0) dcyc = c;
            end
        end
        start = 1'b0;
        cancel = 1'b0;
    endtask

    initial begin
        int dcyc, ndone, berr, d8;
        logic dz1, edz;
        logic [31:0] eh, el, ra, rb;
        logic [3:0] ro;

        vt[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vt[1] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vt[2] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vt[3] = '{MDU_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vt[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vt[5] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vt[6] = '{MDU_DIV,   32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0};
        vt[7] = '{MDU_DIV,   32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'h0000_0001, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_result", result, 0);
        rst = 1'b1;
        rst8 = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, 0, 0, dcyc, ndone, berr, dz1);
            chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vt[i].lo);
            chk($sformatf("vec%0d_dz", i), div_zero, vt[i].dz);
            chk($sformatf("vec%0d_done_cycle", i), dcyc, 34);
            chk($sformatf("vec%0d_done_count", i), ndone, 1);
            chk($sformatf("vec%0d_busy_errs", i), berr, 0);
        end

        // div_zero sticks across idle cycles and MT writes
        repeat (3) @(negedge clk);
        chk("dz_sticky", div_zero, 1);

        @(negedge clk);
        op = MDU_MTHI; in1 = 32'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = MDU_MFHI;
        #1;
        chk("mthi_result", result, 32'h1234);
        chk("mthi_busy", busy, 0);
        chk("mthi_done", done, 0);
        @(negedge clk);
        op = MDU_MTLO; in1 = 32'h5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = MDU_MFLO;
        #1;
        chk("mtlo_result", result, 32'h5678);
        chk("mtlo_hi_kept", hi, 32'h1234);
        op = MDU_MULT;
        #1;
        chk("result_other_op", result, 0);
        chk("dz_after_mt", div_zero, 1);

        // cancel together with start in IDLE blocks the start
        @(negedge clk);
        op = MDU_MTHI; in1 = 32'hDEAD; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_hi", hi, 32'h1234);

        // unknown op does nothing
        @(negedge clk);
        op = 4'hF; in1 = 32'hBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("unk_busy", busy, 0);
        chk("unk_hi", hi, 32'h1234);
        chk("unk_lo", lo, 32'h5678);

        // cancel at cycle 10: idle in cycle 11, HI/LO kept, no done
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10, dcyc, ndone, berr, dz1);
        chk("cxl_dz_cleared", dz1, 0);
        chk("cxl_busy_errs", berr, 0);
        chk("cxl_done_count", ndone, 0);
        chk("cxl_hi", hi, 32'h1234);
        chk("cxl_lo", lo, 32'h5678);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, dcyc, ndone, berr, dz1);
        chk("rerun_hi", hi, 32'hFFFF_FFFE);
        chk("rerun_lo", lo, 32'h1);
        chk("rerun_done_cycle", dcyc, 34);

        // start while busy is ignored
        run_op(MDU_MULT, 32'd3, 32'd4, 4, 0, dcyc, ndone, berr, dz1);
        chk("busy_start_hi", hi, 0);
        chk("busy_start_lo", lo, 12);
        chk("busy_start_done_count", ndone, 1);
        chk("busy_start_busy_errs", berr, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            model(ro, ra, rb, eh, el, edz);
            run_op(ro, ra, rb, 0, 0, dcyc, ndone, berr, dz1);
            chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, ro, ra, rb), hi, eh);
            chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, ro, ra, rb), lo, el);
            chk($sformatf("rnd%0d_dz", i), div_zero, edz);
            chk($sformatf("rnd%0d_done_cycle", i), dcyc, 34);
        end

        // WIDTH=8: MULT 0x80 x 0x80, done at cycle 10
        @(negedge clk);
        op8 = MDU_MULT; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        d8 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8 === 1'b1 && d8 == 0) d8 = c;
        end
        chk("w8_done_cycle", d8, 10);
        chk("w8_hi", hi8, 8'h40);
        chk("w8_lo", lo8, 8'h00);

        // WIDTH=8: reset at cycle 5 of a DIV clears everything at once
        @(negedge clk);
        op8 = MDU_DIV; a8 = 8'h55; b8 = 8'h03; start8 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        chk("w8_busy_before_rst", busy8, 1);
        rst8 = 1'b0;
        #1;
        chk("w8_rst_hi", hi8, 0);
        chk("w8_rst_lo", lo8, 0);
        chk("w8_rst_busy", busy8, 0);
        chk("w8_rst_done", done8, 0);
        chk("w8_rst_dz", dz8, 0);
        @(negedge clk);
        rst8 = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
